// File: rtl/fixed_div_if.sv
// fixed_div_if: operand/result handshake bundle for the fixed_div Q16.15 divider.
//   in_valid/in_ready   operand handshake; a_in/b_in carry dividend/divisor
//   out_valid/out_ready result handshake; q_out carries the quotient,
//                       div_zero_out/overflow_out are qualified by out_valid
// master: producer/consumer side (testbench or upstream logic)
// slave:  the divider itself
interface fixed_div_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] q_out;
    logic        div_zero_out;
    logic        overflow_out;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, q_out, div_zero_out, overflow_out
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, q_out, div_zero_out, overflow_out
    );
endinterface

// File: rtl/fixed_div.sv
// fixed_div: sequential signed divider for the 32-bit Q16.15 fixed type, q = a / b.
// Restoring division, one quotient bit per cycle over a 47-bit dividend (|a| << 15).
// Ports:
//   clk_in  rising-edge clock
//   rst_in  asynchronous active-high reset; discards any in-flight operation
//   bus     fixed_div_if.slave: operand handshake (in_valid/in_ready, a_in, b_in) and
//           result handshake (out_valid/out_ready, q_out, div_zero_out, overflow_out)
// Optional feature: define FIXED_DIV_ROUND_EN to round the magnitude half away from zero
// instead of truncating toward zero. Latency is the same either way.
module fixed_div (
    input  logic       clk_in,
    input  logic       rst_in,
    fixed_div_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [32:0] rem_q, rem_d;
    logic [46:0] num_q, num_d;   // dividend, shifted out MSB first
    logic [46:0] quo_q, quo_d;
    logic [31:0] den_q, den_d;   // |b|
    logic        sign_q, sign_d;
    logic [31:0] q_q, q_d;
    logic        dz_q, dz_d;
    logic        ovf_q, ovf_d;

    logic [31:0] a_mag, b_mag;
    logic [32:0] rem_sh, rem_nx;
    logic        ge;
    logic [46:0] quo_nx;
    logic        round_up;
    logic [47:0] mag;
    logic [31:0] res_val;
    logic        res_ovf;

    // |0x80000000| wraps back to 0x80000000, which read unsigned is exactly 2^31.
    assign a_mag = bus.a_in[31] ? (~bus.a_in + 32'd1) : bus.a_in;
    assign b_mag = bus.b_in[31] ? (~bus.b_in + 32'd1) : bus.b_in;

    // The remainder stays below |b| <= 2^31, so its top bit is always clear before the shift.
    assign rem_sh = {rem_q[31:0], num_q[46]};
    assign ge     = rem_sh >= {1'b0, den_q};
    assign rem_nx = ge ? (rem_sh - {1'b0, den_q}) : rem_sh;
    assign quo_nx = {quo_q[45:0], ge};

`ifdef FIXED_DIV_ROUND_EN
    assign round_up = {rem_nx, 1'b0} >= {2'b00, den_q};
`else
    assign round_up = 1'b0;
`endif

    // Result is formed from the final iteration's values so DONE is entered on that same edge.
    assign mag = {1'b0, quo_nx} + {47'd0, round_up};

    always_comb begin
        res_val = '0;
        res_ovf = 1'b0;
        if (!sign_q) begin
            if (mag > 48'h0000_7FFF_FFFF) begin
                res_val = 32'h7FFF_FFFF;
                res_ovf = 1'b1;
            end else begin
                res_val = mag[31:0];
            end
        end else begin
            if (mag > 48'h0000_8000_0000) begin
                res_val = 32'h8000_0000;
                res_ovf = 1'b1;
            end else begin
                // Magnitude 2^31 negates to exactly 0x80000000; zero stays zero.
                res_val = ~mag[31:0] + 32'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        num_d   = num_q;
        quo_d   = quo_q;
        den_d   = den_q;
        sign_d  = sign_q;
        q_d     = q_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    sign_d = bus.a_in[31] ^ bus.b_in[31];
                    den_d  = b_mag;
                    num_d  = {a_mag, 15'd0};
                    rem_d  = '0;
                    quo_d  = '0;
                    cnt_d  = 6'd46;
                    if (bus.b_in == 32'd0) begin
                        q_d     = bus.a_in[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        dz_d    = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = StDone;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                num_d = {num_q[45:0], 1'b0};
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd0) begin
                    cnt_d   = '0;
                    q_d     = res_val;
                    ovf_d   = res_ovf;
                    dz_d    = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            num_q   <= '0;
            quo_q   <= '0;
            den_q   <= '0;
            sign_q  <= 1'b0;
            q_q     <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            num_q   <= num_d;
            quo_q   <= quo_d;
            den_q   <= den_d;
            sign_q  <= sign_d;
            q_q     <= q_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready     = (state_q == StIdle);
    assign bus.out_valid    = (state_q == StDone);
    assign bus.q_out        = q_q;
    assign bus.div_zero_out = dz_q;
    assign bus.overflow_out = ovf_q;
endmodule
